// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared request encodings and lane helpers for mem_responder
package mem_pkg;

    typedef enum logic {M_RD = 1'b0, M_WR = 1'b1} mem_fcn_e;
    typedef enum logic [1:0] {MT_B = 2'd0, MT_H = 2'd1, MT_W = 2'd2, MT_X = 2'd3} mem_typ_e;

    function automatic logic [3:0] byte_mask(input mem_typ_e typ, input logic [1:0] lane);
        case (typ)
            MT_B:    byte_mask = 4'b0001 << lane;
            MT_H:    byte_mask = lane[1] ? 4'b1100 : 4'b0011;
            MT_W:    byte_mask = 4'b1111;
            default: byte_mask = 4'b0000;
        endcase
    endfunction

    // Store data arrives right-aligned; copy it into every lane the mask might select.
    function automatic logic [31:0] store_replicate(input mem_typ_e typ, input logic [31:0] data);
        case (typ)
            MT_B:    store_replicate = {4{data[7:0]}};
            MT_H:    store_replicate = {2{data[15:0]}};
            default: store_replicate = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input mem_typ_e typ,
                                                input logic [1:0] lane, input logic uns);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (typ)
            MT_B:    load_extend = {{24{~uns & shifted[7]}}, shifted[7:0]};
            MT_H:    load_extend = {{16{~uns & shifted[15]}}, shifted[15:0]};
            MT_W:    load_extend = word;
            default: load_extend = 32'd0;
        endcase
    endfunction

    function automatic logic misaligned(input mem_typ_e typ, input logic [1:0] lane);
        case (typ)
            MT_H:    misaligned = lane[0];
            MT_W:    misaligned = (lane != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// rtl/mem_resp_pipe.sv - LATENCY-deep valid/err/data response shift register
module mem_resp_pipe #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_err,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic        out_err,
    output logic [31:0] out_data
);

    logic        valid_q [LATENCY];
    logic        err_q   [LATENCY];
    logic [31:0] data_q  [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) valid_q[i] <= 1'b0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        err_q[0]  <= in_err;
        data_q[0] <= in_data;
        for (int i = 1; i < LATENCY; i++) begin
            err_q[i]  <= err_q[i-1];
            data_q[i] <= data_q[i-1];
        end
    end

    // Payload is not reset, so qualify it with the last valid bit.
    assign out_valid = valid_q[LATENCY-1];
    assign out_err   = valid_q[LATENCY-1] & err_q[LATENCY-1];
    assign out_data  = valid_q[LATENCY-1] ? data_q[LATENCY-1] : 32'd0;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency memory responder with stall injection
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 4096,
    parameter int LATENCY      = 1,
    parameter int STALL_PERIOD = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_fcn,
    input  logic [1:0]  req_typ,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = (STALL_PERIOD > 0) ? CW'(STALL_PERIOD - 1) : '0;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [CW-1:0] stall_cnt, cnt_next;
    logic          ready_q;

    mem_typ_e      typ;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic          accept, is_write, err;
    logic [3:0]    wmask;
    logic [31:0]   wdata, rdata;

    always_comb begin
        typ      = mem_typ_e'(req_typ);
        lane     = req_addr[1:0];
        idx      = req_addr[AW+1:2];
        accept   = req_valid && ready_q;
        is_write = (mem_fcn_e'(req_fcn) == M_WR);
        err      = ((req_addr >> (AW + 2)) != 32'd0) || (typ == MT_X) || misaligned(typ, lane);
        wmask    = byte_mask(typ, lane);
        wdata    = store_replicate(typ, req_data);
        rdata    = (is_write || err) ? 32'd0 : load_extend(mem[idx], typ, lane, req_unsigned);
    end

    always_comb begin
        cnt_next = '0;
        if (STALL_PERIOD > 1 && stall_cnt != CNT_LAST) cnt_next = stall_cnt + CW'(1);
    end

    // Ready is registered from the next counter value so it lines up with the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            ready_q   <= 1'b0;
        end else begin
            stall_cnt <= cnt_next;
            ready_q   <= (STALL_PERIOD == 0) || (cnt_next != CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (accept && is_write && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    mem_resp_pipe #(.LATENCY(LATENCY)) u_pipe (
        .clk      (clk),
        .rst      (reset),
        .in_valid (accept),
        .in_err   (err),
        .in_data  (rdata),
        .out_valid(res_valid),
        .out_err  (res_err),
        .out_data (res_data)
    );

    assign req_ready = ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;
    localparam int STALL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_fcn;
    logic [1:0]  req_typ;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_err;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .STALL_PERIOD(STALL)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_fcn     (req_fcn),
        .req_typ     (req_typ),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_err     (res_err)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] ref_mem [4*DEPTH];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         since   = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge reset) begin
        if (reset) since <= 0;
        else       since <= since + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Byte-addressed little-endian reference memory.
    function automatic void model(input bit wr, input logic [1:0] typ, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] data,
                                  output logic err, output logic [31:0] rd);
        int n;
        logic [31:0] sh;
        n  = 1 << typ;
        rd = '0;
        err = (typ == 2'd3) || (addr >= 32'(4 * DEPTH)) || (addr % n != 0);
        if (err) return;
        for (int k = 0; k < n; k++) begin
            if (wr) begin
                sh = data >> (8 * k);
                ref_mem[addr + k] = sh[7:0];
            end else begin
                rd = rd | (32'(ref_mem[addr + k]) << (8 * k));
            end
        end
        if (!wr && !uns && n < 4 && rd[8 * n - 1]) rd = rd | ~((32'd1 << (8 * n)) - 32'd1);
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input bit wr, input logic [1:0] typ, input bit uns,
                         input logic [31:0] addr, input logic [31:0] data);
        int   waits;
        exp_t x;
        waits        = 0;
        req_valid    = 1'b1;
        req_fcn      = wr;
        req_typ      = typ;
        req_unsigned = uns;
        req_addr     = addr;
        req_data     = data;
        while (!req_ready && waits < 20) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!req_ready) begin
            check("ready_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        model(wr, typ, uns, addr, data, x.err, x.data);
        if (wr) x.data = 32'd0;
        x.due = cyc + LAT;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("reset_outputs", {28'd0, req_ready, res_valid, res_err, |res_data}, 32'd0);
        end else begin
            check("req_ready", {31'd0, req_ready}, {31'd0, (since > 0) && ((since % STALL) != STALL - 1)});
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_res_valid", {31'd0, res_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_cycle", 32'(cyc), 32'(e.due));
                    check("res_data", res_data, e.data);
                    check("res_err", {31'd0, res_err}, {31'd0, e.err});
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                check("missing_res_valid", {31'd0, res_valid}, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  t;
        logic [31:0] a;
        reset = 1'b1; req_valid = 1'b0; req_fcn = 1'b0; req_typ = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int w = 0; w < DEPTH; w++) issue(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom());

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h80);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h8001);
        issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);

        for (int i = 0; i < 12; i++) issue(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0);

        for (int i = 0; i < 300; i++) begin
            t = 2'($urandom_range(0, 3));
            a = $urandom_range(0, 4 * DEPTH + 15);
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << t) - 32'd1);
            issue(1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)), a, $urandom());
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h24, 32'h0);
        reset = 1'b1;
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);

        repeat (LAT + 2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
